uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_edge_rise.sv | 24 ++
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter (and the planned receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Wide enough to count up to 9 data bits.
  localparam int UART_CNT_W = 4;

endpackage

// File: rtl/uart_tx_edge_rise.sv
// Rising-edge detector for a level that is already synchronous to clk.
// The previous sample resets high so a level that is high out of reset gives no pulse.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = level_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign pulse_out = level_in & ~prev_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter paced by rising edges of the divided clock level baud_in.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [UART_CNT_W-1:0] LAST_DATA = UART_CNT_W'(DATA_BITS - 1);
  localparam logic [UART_CNT_W-1:0] LAST_STOP = UART_CNT_W'(STOP_BITS - 1);

  uart_tx_state_t         state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   tx_q, tx_d;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  edge_rise u_edge_rise (
    .clk       (clk),
    .rst       (rst),
    .level_in  (baud_in),
    .pulse_out (tick)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        // A tick in the handshake cycle is deliberately ignored.
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = '0;
          state_d = WAIT_TICK;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          tx_d    = ~UART_IDLE_LEVEL;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = UART_IDLE_LEVEL;
            state_d = STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level bit-queue model checked every cycle,
// plus directed literal checks for timing, back-to-back frames, reset and parity.
module tb_uart_tx;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FACTOR    = 100;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

  typedef logic bitq_t[$];

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 baud_in = 1'b1;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_valid = 1'b0;
  logic                 tx_ready, tx, busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ph    = 10;
  bit baud_run = 1'b0;

  uart_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_in  (baud_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Divided clock: high for the first half of each FACTOR-cycle period; freezes when stalled.
  always @(negedge clk) begin
    if (baud_run) ph = (ph + 1) % FACTOR;
    baud_in = (ph < FACTOR / 2);
  end

  // Reference model: a frame is a queue of line levels, one popped per bit-boundary tick.
  logic  m_tx = 1'b1, m_ready = 1'b1, m_busy = 1'b0, m_prev = 1'b1;
  bit    m_tick;
  bitq_t m_q;

  function automatic bitq_t frame_bits(input logic [DATA_BITS-1:0] d);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) q.push_back(d[i]);
    if (PAR_BITS == 1) q.push_back(^d);
    for (int i = 0; i < STOP_BITS; i++) q.push_back(1'b1);
    return q;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tx = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_prev = 1'b1;
      m_q.delete();
    end else begin
      m_tick = baud_in & ~m_prev;
      m_prev = baud_in;
      if (m_ready && tx_valid) begin
        m_q = frame_bits(tx_data);
        m_ready = 1'b0;
        m_busy  = 1'b1;
      end else if (m_busy && m_tick) begin
        if (m_q.size() > 0) m_tx = m_q.pop_front();
        else begin
          m_busy  = 1'b0;
          m_ready = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    check("tx", tx, m_tx);
    check("tx_ready", tx_ready, m_ready);
    check("busy", busy, m_busy);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input logic lvl, input int budget, input string nm, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      if (tx === lvl) t = cyc; else step();
    end
    check({nm, " seen"}, (t >= 0), 1);
  endtask

  task automatic wait_ready(input int budget, input string nm, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      if (tx_ready === 1'b1) t = cyc; else step();
    end
    check({nm, " seen"}, (t >= 0), 1);
  endtask

  task automatic send(input logic [DATA_BITS-1:0] d, input int budget, output int h);
    h = -1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < budget && h < 0; i++) begin
      if (tx_ready === 1'b1) h = cyc; else step();
    end
    check("handshake taken", (h >= 0), 1);
    step();
    tx_valid = 1'b0;
    tx_data  = DATA_BITS'($urandom);
  endtask

  // Checks each line level at the first and last cycle of its bit period, then frame length.
  task automatic frame_check(input string nm, input logic [DATA_BITS-1:0] d, input logic [15:0] lv);
    int h, f, r;
    send(d, 4 * FRAME_BITS * FACTOR, h);
    wait_tx(1'b0, 2 * FACTOR + 4, {nm, " start"}, f);
    for (int k = 0; k < FRAME_BITS; k++) begin
      while (cyc < f + k * FACTOR) step();
      check({nm, " bit begin"}, tx, lv[k]);
      while (cyc < f + (k + 1) * FACTOR - 1) step();
      check({nm, " bit end"}, tx, lv[k]);
    end
    wait_ready(2 * FACTOR, {nm, " ready"}, r);
    check({nm, " frame length"}, r - f, FRAME_BITS * FACTOR);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, f, f1, f2, r, low, n_wait;
`ifdef UART_TX_PARITY_EN
    logic [15:0] lv55 = 16'h04AA;
`else
    logic [15:0] lv55 = 16'h02AA;
`endif

    // Reset held with the divider output high.
    rst = 1'b1; baud_run = 1'b0; ph = 10;
    repeat (4) step();
    rst = 1'b0;
    step();
    check("reset tx", tx, 1);
    check("reset tx_ready", tx_ready, 1);
    check("reset busy", busy, 0);
    repeat (3) step();
    baud_run = 1'b1;

    // Single byte, alternating pattern: every bit period exactly FACTOR cycles.
    frame_check("b55", 8'h55, lv55);

    // Handshake in the very cycle of a tick: start bit waits for the following tick.
    while (ph != 0) step();
    send(8'hC4, 10, h);
    wait_tx(1'b0, 2 * FACTOR + 4, "coincident start", f);
    check("coincident start delay", f - h, FACTOR + 1);
    wait_ready(2 * FRAME_BITS * FACTOR, "coincident ready", r);

    // Back-to-back frames with tx_valid held high throughout.
    tx_data = 8'hA3; tx_valid = 1'b1;
    wait_ready(10, "b2b first ready", h1);
    step();
    tx_data = 8'h0F;
    wait_tx(1'b0, 2 * FACTOR + 4, "b2b first start", f1);
    wait_ready(2 * FRAME_BITS * FACTOR, "b2b second ready", r);
    step();
    check("b2b ready one cycle", tx_ready, 0);
    check("b2b busy again", busy, 1);
    tx_valid = 1'b0;
    wait_tx(1'b0, 2 * FACTOR + 4, "b2b second start", f2);
    // Stop period(s) plus one idle-high bit period separate the frames.
    check("b2b start spacing", f2 - f1, (FRAME_BITS + 1) * FACTOR);
    check("b2b idle gap", f2 - r, FACTOR);
    wait_ready(2 * FRAME_BITS * FACTOR, "b2b end", r);

`ifdef UART_TX_PARITY_EN
    frame_check("par07", 8'h07, 16'h060E);
    frame_check("par03", 8'h03, 16'h0406);
`endif

    // Reset in the middle of data bit 3 of an all-zero byte.
    send(8'h00, 10, h);
    wait_tx(1'b0, 2 * FACTOR + 4, "rst_mid start", f);
    while (cyc < f + 4 * FACTOR + FACTOR / 2) step();
    check("rst_mid before", tx, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid async tx", tx, 1);
    check("rst_mid async busy", busy, 0);
    step(); step();
    rst = 1'b0;
    step();
    check("rst_mid ready", tx_ready, 1);
    low = 0;
    repeat (FRAME_BITS * FACTOR + 200) begin
      step();
      if (tx !== 1'b1) low++;
    end
    check("rst_mid no residual bits", low, 0);

    // Randomized traffic with ignored valids while busy and stalled divider output.
    for (int n = 0; n < 20; n++) begin
      n_wait = $urandom_range(0, 250);
      for (int i = 0; i < n_wait; i++) step();
      send(DATA_BITS'($urandom), 4 * FRAME_BITS * FACTOR, h);
      n_wait = $urandom_range(0, FRAME_BITS * FACTOR);
      for (int i = 0; i < n_wait; i++) begin
        step();
        if (busy === 1'b1 && $urandom_range(0, 19) == 0) begin
          tx_valid = 1'b1;
          tx_data  = DATA_BITS'($urandom);
          step();
          tx_valid = 1'b0;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        baud_run = 1'b0;
        repeat ($urandom_range(1, 400)) step();
        baud_run = 1'b1;
      end
    end
    wait_ready(4 * FRAME_BITS * FACTOR, "final idle", r);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
